fifo_read_checker: RTL and testbench

//  Read-side consumer/scoreboard for asynchronous_fifo, living entirely in the rclk domain.

---
 rtl/fifo_read_checker_if.sv | 11 +
 rtl/fifo_read_checker.sv | 162 ++++++++++++++++
 tb/tb_fifo_read_checker.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_checker_if.sv
// FIFO read-port bundle shared by an asynchronous_fifo read side and its consumer.
interface fifo_read_checker_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  r_en;
    logic                  empty;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (output r_en, input empty, input rd_data);
    modport slave  (input r_en, output empty, output rd_data);
endinterface

// File: rtl/fifo_read_checker.sv
// Read-side ramp scoreboard for asynchronous_fifo: polls, pops and checks an incrementing ramp.
// Define ERR_CAPTURE_EN to add first-mismatch capture outputs.
module fifo_read_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = 256,
    parameter int START_VAL  = 0,
    parameter int RD_GAP     = 4,
    parameter int TIMEOUT    = 1024,
    localparam int CW        = $clog2(NUM_WORDS + 1)
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  start,
    fifo_read_checker_if.master   rd,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CW-1:0]         word_cnt,
    output logic [CW-1:0]         err_cnt
`ifdef ERR_CAPTURE_EN
    ,
    output logic [CW-1:0]         first_err_idx,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_act
`endif
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (RD_GAP > 1) ? $clog2(RD_GAP) : 1;
    localparam logic [TW-1:0]         TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]         GAP_LAST = GW'((RD_GAP > 0) ? RD_GAP - 1 : 0);
    localparam logic [CW-1:0]         NW_LAST  = CW'(NUM_WORDS);
    localparam logic [DATA_WIDTH-1:0] EXP_INIT = DATA_WIDTH'(START_VAL);

    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_ISSUE, S_CHECK, S_GAP, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  r_en_q, r_en_d;
    logic                  timeout_q, timeout_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic [CW-1:0]         err_cnt_q, err_cnt_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  mismatch;
    logic                  first_err;

    assign mismatch  = (rd.rd_data != exp_q);
    // Only the first mismatch of a run sees a zero error count.
    assign first_err = (state_q == S_CHECK) && mismatch && (err_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        r_en_d     = 1'b0;
        timeout_d  = timeout_q;
        to_cnt_d   = '0;
        gap_cnt_d  = '0;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        exp_d      = exp_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_POLL;
            end
            S_POLL: begin
                if (!rd.empty) begin
                    state_d = S_ISSUE;
                    r_en_d  = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_ISSUE: state_d = S_CHECK;
            S_CHECK: begin
                // rd_data is the word popped on the ISSUE closing edge.
                word_cnt_d = word_cnt_q + CW'(1);
                exp_d      = exp_q + DATA_WIDTH'(1);
                if (mismatch) err_cnt_d = err_cnt_q + CW'(1);
                if (word_cnt_d == NW_LAST) state_d = S_DONE;
                else if (RD_GAP > 0)       state_d = S_GAP;
                else                       state_d = S_POLL;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_POLL;
                else                       gap_cnt_d = gap_cnt_q + GW'(1);
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q    <= S_IDLE;
            r_en_q     <= 1'b0;
            timeout_q  <= 1'b0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            exp_q      <= EXP_INIT;
        end else begin
            state_q    <= state_d;
            r_en_q     <= r_en_d;
            timeout_q  <= timeout_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
            exp_q      <= exp_d;
        end
    end

`ifdef ERR_CAPTURE_EN
    logic [CW-1:0]         fe_idx_q, fe_idx_d;
    logic [DATA_WIDTH-1:0] fe_exp_q, fe_exp_d;
    logic [DATA_WIDTH-1:0] fe_act_q, fe_act_d;

    always_comb begin
        fe_idx_d = fe_idx_q;
        fe_exp_d = fe_exp_q;
        fe_act_d = fe_act_q;
        if (first_err) begin
            fe_idx_d = word_cnt_q;
            fe_exp_d = exp_q;
            fe_act_d = rd.rd_data;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            fe_idx_q <= '0;
            fe_exp_q <= '0;
            fe_act_q <= '0;
        end else begin
            fe_idx_q <= fe_idx_d;
            fe_exp_q <= fe_exp_d;
            fe_act_q <= fe_act_d;
        end
    end

    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_act = fe_act_q;
`else
    logic unused_first_err;
    assign unused_first_err = first_err;
`endif

    assign rd.r_en  = r_en_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign timeout  = timeout_q;
    assign pass     = done & ~timeout_q & (err_cnt_q == '0);
    assign word_cnt = word_cnt_q;
    assign err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_fifo_read_checker.sv
// Bench for fifo_read_checker: three parameterisations, each beside a queue-like FIFO model
// and a transaction-level scoreboard, plus directed scenarios with literal expectations.
module tb_fifo_read_checker;
    localparam int DW    = 8;
    localparam int NI    = 3;
    localparam int DEPTH = 2048;

    function automatic int f_nw(input int g);  return (g == 1) ? 10 : 256;   endfunction
    function automatic int f_sv(input int g);  return (g == 1) ? 250 : 0;    endfunction
    function automatic int f_gap(input int g); return (g == 1) ? 0 : 4;      endfunction
    function automatic int f_to(input int g);  return (g == 2) ? 16 : 1024;  endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst    [NI];
    logic          start  [NI];
    logic [DW-1:0] mem    [NI][DEPTH];
    int            wr_ptr [NI];
    int            rd_ptr [NI];
    int            pops   [NI];
    int            rise1  [NI];
    int            rise2  [NI];
    logic          busy_o [NI];
    logic          done_o [NI];
    logic          pass_o [NI];
    logic          tmo_o  [NI];
    logic          ren_o  [NI];
    int            wc_o   [NI];
    int            ec_o   [NI];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int g, input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL i%0d %s: got %0d, expected %0d (t=%0t)", g, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_ch
        localparam int NW = f_nw(g);
        localparam int SV = f_sv(g);
        localparam int GP = f_gap(g);
        localparam int TO = f_to(g);
        localparam int CW = $clog2(NW + 1);

        fifo_read_checker_if #(.DATA_WIDTH(DW)) rif ();
        logic [CW-1:0] wc, ec;
`ifdef ERR_CAPTURE_EN
        logic [CW-1:0] fei;
        logic [DW-1:0] fee, fea;
`endif

        fifo_read_checker #(
            .DATA_WIDTH(DW), .NUM_WORDS(NW), .START_VAL(SV), .RD_GAP(GP), .TIMEOUT(TO)
        ) dut (
            .rclk(clk), .rrst(rst[g]), .start(start[g]), .rd(rif.master),
            .busy(busy_o[g]), .done(done_o[g]), .pass(pass_o[g]), .timeout(tmo_o[g]),
            .word_cnt(wc), .err_cnt(ec)
`ifdef ERR_CAPTURE_EN
            , .first_err_idx(fei), .first_err_exp(fee), .first_err_act(fea)
`endif
        );

        assign wc_o[g]   = int'(wc);
        assign ec_o[g]   = int'(ec);
        assign ren_o[g]  = rif.r_en;
        assign rif.empty = (rd_ptr[g] == wr_ptr[g]);

        // FIFO read port: data_out updates on the r_en edge.
        always @(posedge clk) begin
            if (rif.r_en) begin
                rif.rd_data <= mem[g][rd_ptr[g] % DEPTH];
                rd_ptr[g]   <= rd_ptr[g] + 1;
                pops[g]     <= pops[g] + 1;
            end
        end

        // Scoreboard: run phase 0=idle 1=running 2=finished; timeout predicted as a deadline edge.
        int m_words, m_errs, m_exp, m_run, m_tmo, m_dl, m_s, m_val, m_fi, m_fe, m_fa;
        bit m_pend;
        always @(posedge clk or posedge rst[g]) begin
            if (rst[g]) begin
                m_words = 0; m_errs = 0; m_exp = SV % 256; m_run = 0; m_tmo = 0;
                m_dl = -1; m_s = 0; m_pend = 1'b0; m_fi = 0; m_fe = 0; m_fa = 0;
            end else begin : step
                int n;
                n = cyc + 1;
                if (m_run == 0) begin
                    if (start[g]) begin m_run = 1; m_s = n; m_dl = n + TO; end
                end else if (m_run == 1) begin
                    if (m_pend) begin
                        if (m_val != m_exp) begin
                            if (m_errs == 0) begin m_fi = m_words; m_fe = m_exp; m_fa = m_val; end
                            m_errs++;
                        end
                        m_words++;
                        m_exp  = (m_exp + 1) % 256;
                        m_pend = 1'b0;
                        if (m_words == NW) m_run = 2;
                        else               m_dl  = n + GP + TO;
                    end else if (ren_o[g]) begin
                        m_pend = 1'b1;
                        m_val  = int'(mem[g][rd_ptr[g] % DEPTH]);
                        m_dl   = -1;
                    end else if (n == m_dl) begin
                        m_run = 2;
                        m_tmo = 1;
                    end
                end
            end
        end

        int prev_rise = -1;
        int nrise     = 0;
        bit starved   = 1'b0;
        bit ren_prev  = 1'b0;
        always @(negedge clk) begin
            if (m_run == 0) begin prev_rise = -1; nrise = 0; starved = 1'b0; end
            chk(g, "word_cnt", wc_o[g], m_words);
            chk(g, "err_cnt", ec_o[g], m_errs);
            chk(g, "busy", busy_o[g], (m_run == 1));
            chk(g, "done", done_o[g], (m_run == 2));
            chk(g, "timeout", tmo_o[g], m_tmo);
            chk(g, "pass", pass_o[g], (m_run == 2 && m_tmo == 0 && m_errs == 0));
`ifdef ERR_CAPTURE_EN
            chk(g, "first_err_idx", fei, m_fi);
            chk(g, "first_err_exp", fee, m_fe);
            chk(g, "first_err_act", fea, m_fa);
`endif
            if (ren_o[g]) begin
                chk(g, "r_en while empty", rif.empty, 0);
                chk(g, "r_en pulse width", ren_prev, 0);
                chk(g, "r_en outside run", m_run, 1);
                if (!starved)
                    chk(g, "r_en spacing", cyc - ((prev_rise < 0) ? m_s : prev_rise),
                        (prev_rise < 0) ? 1 : 3 + GP);
                if (nrise == 0) rise1[g] <= cyc;
                if (nrise == 1) rise2[g] <= cyc;
                nrise++;
                prev_rise = cyc;
                starved   = 1'b0;
            end else if (m_run == 1 && rif.empty) begin
                starved = 1'b1;
            end
            ren_prev = ren_o[g];
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset(input int g);
        rst[g]   = 1'b1;
        start[g] = 1'b0;
        repeat (2) tick();
        wr_ptr[g] = rd_ptr[g];
        rst[g]    = 1'b0;
        tick();
    endtask

    task automatic load_ramp(input int g, input int first, input int count,
                             input int bad_idx, input int bad_val);
        for (int i = 0; i < count; i++) begin
            mem[g][wr_ptr[g] % DEPTH] = (i == bad_idx) ? DW'(bad_val) : DW'(first + i);
            wr_ptr[g] = wr_ptr[g] + 1;
        end
    endtask

    task automatic wait_done(input int g, input int budget, input string nm);
        int k;
        k = 0;
        while (!done_o[g] && k < budget) begin tick(); k++; end
        chk(g, nm, done_o[g], 1);
    endtask

    initial begin
        int p, k;
        for (int i = 0; i < NI; i++) begin rst[i] = 1'b1; start[i] = 1'b0; wr_ptr[i] = 0; end
        tick();
        for (int i = 0; i < NI; i++) begin
            chk(i, "reset word_cnt", wc_o[i], 0);
            chk(i, "reset done", done_o[i], 0);
            chk(i, "reset r_en", ren_o[i], 0);
            chk(i, "reset timeout", tmo_o[i], 0);
        end

        // T1 + T5 (RD_GAP=4): clean 256-word ramp
        do_reset(0);
        load_ramp(0, 0, 256, -1, 0);
        p = pops[0];
        start[0] = 1'b1;
        wait_done(0, 3000, "T1 done reached");
        repeat (3) tick();
        chk(0, "T1 pass", pass_o[0], 1);
        chk(0, "T1 word_cnt", wc_o[0], 256);
        chk(0, "T1 err_cnt", ec_o[0], 0);
        chk(0, "T1 r_en pulses", pops[0] - p, 256);
        chk(0, "T5 spacing gap4", rise2[0] - rise1[0], 7);

        // T2: word 10 corrupted
        do_reset(0);
        load_ramp(0, 0, 256, 10, 'hAA);
        start[0] = 1'b1;
        wait_done(0, 3000, "T2 done reached");
        chk(0, "T2 err_cnt", ec_o[0], 1);
        chk(0, "T2 pass", pass_o[0], 0);
        chk(0, "T2 word_cnt", wc_o[0], 256);
`ifdef ERR_CAPTURE_EN
        chk(0, "T2 first_err_idx", g_ch[0].fei, 10);
        chk(0, "T2 first_err_exp", g_ch[0].fee, 'h0A);
        chk(0, "T2 first_err_act", g_ch[0].fea, 'hAA);
`endif

        // T3 + T5 (RD_GAP=0): wrap-around from 250
        do_reset(1);
        load_ramp(1, 250, 10, -1, 0);
        p = pops[1];
        start[1] = 1'b1;
        wait_done(1, 200, "T3 done reached");
        chk(1, "T3 pass", pass_o[1], 1);
        chk(1, "T3 word_cnt", wc_o[1], 10);
        chk(1, "T3 r_en pulses", pops[1] - p, 10);
        chk(1, "T5 spacing gap0", rise2[1] - rise1[1], 3);

        // T4: empty forever, TIMEOUT=16
        do_reset(2);
        p = pops[2];
        start[2] = 1'b1;
        tick();
        chk(2, "T4 busy in poll", busy_o[2], 1);
        repeat (15) tick();
        chk(2, "T4 done before 16 polls", done_o[2], 0);
        tick();
        chk(2, "T4 done after 16 polls", done_o[2], 1);
        chk(2, "T4 timeout", tmo_o[2], 1);
        chk(2, "T4 pass", pass_o[2], 0);
        chk(2, "T4 no r_en", pops[2] - p, 0);

        // T6: reset mid-run after word 100, then rerun
        do_reset(0);
        load_ramp(0, 0, 256, -1, 0);
        p = pops[0];
        start[0] = 1'b1;
        k = 0;
        while (wc_o[0] < 100 && k < 2000) begin tick(); k++; end
        chk(0, "T6 reached word 100", wc_o[0], 100);
        k = 0;
        while (!ren_o[0] && k < 50) begin tick(); k++; end
        chk(0, "T6 r_en before reset", ren_o[0], 1);
        rst[0] = 1'b1;
        #1;
        chk(0, "T6 r_en async drop", ren_o[0], 0);
        chk(0, "T6 busy reset", busy_o[0], 0);
        chk(0, "T6 word_cnt reset", wc_o[0], 0);
        chk(0, "T6 done reset", done_o[0], 0);
        repeat (2) tick();
        chk(0, "T6 in-flight not popped", pops[0] - p, 100);
        do_reset(0);
        load_ramp(0, 0, 256, -1, 0);
        start[0] = 1'b1;
        wait_done(0, 3000, "T6 rerun done");
        chk(0, "T6 rerun pass", pass_o[0], 1);
        chk(0, "T6 rerun word_cnt", wc_o[0], 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
